// File: rtl/issue_unit_pkg.sv
// Shared lane/FSM types and the ROB tag width for the issue unit.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

package issue_unit_pkg;

    localparam int NUM_LANES = 4;
    localparam int TAG_W     = `ROB_TAG_LEN;

    typedef enum logic [1:0] {
        LANE_LSU  = 2'd0,
        LANE_MULT = 2'd1,
        LANE_BTU  = 2'd2,
        LANE_ALU  = 2'd3
    } fu_lane_e;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_BUSY  = 2'd1,
        LSU_DRAIN = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/fu_latency_pipe.sv
// Valid+tag shift register modelling a fixed-latency FU; flush drops everything in flight.
module fu_latency_pipe
    import issue_unit_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic [TAG_W-1:0] o_tag
);

    logic [DEPTH-1:0]            r_valid;
    logic [DEPTH-1:0][TAG_W-1:0] r_tag;
    logic [TAG_W-1:0]            w_tag_in;

    // Tags of empty slots are held at zero so the output tag needs no gating.
    assign w_tag_in = i_valid ? i_tag : {TAG_W{1'b0}};

    if (DEPTH == 1) begin : g_single
        // Single-stage pipe register.
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_valid <= '0;
                r_tag   <= '0;
            end else if (i_flush) begin
                r_valid <= '0;
                r_tag   <= '0;
            end else begin
                r_valid <= i_valid;
                r_tag   <= w_tag_in;
            end
        end
    end else begin : g_multi
        // Multi-stage shift toward the top slot.
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                r_valid <= '0;
                r_tag   <= '0;
            end else if (i_flush) begin
                r_valid <= '0;
                r_tag   <= '0;
            end else begin
                r_valid <= {r_valid[DEPTH-2:0], i_valid};
                r_tag   <= {r_tag[DEPTH-2:0], w_tag_in};
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_tag   = r_tag[DEPTH-1];

endmodule

// File: rtl/issue_unit.sv
// Four-lane issue controller: grants, RS clears, completion wakeups and flush squash.
// Optional performance counters are built when ISSUE_UNIT_PERF_EN is defined.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int MULT_LAT = 4
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [NUM_LANES-1:0]            i_req_valid,
    input  logic [NUM_LANES-1:0][TAG_W-1:0] i_req_tag,
    input  logic                            i_flush,
    input  logic                            i_lsu_done,
    output logic [NUM_LANES-1:0]            o_issue_valid,
    output logic [NUM_LANES-1:0][TAG_W-1:0] o_issue_tag,
    output logic [NUM_LANES-1:0]            o_clear,
    output logic [NUM_LANES-1:0][TAG_W-1:0] o_clear_tag,
    output logic [NUM_LANES-1:0]            o_wakeup,
    output logic [NUM_LANES-1:0][TAG_W-1:0] o_wakeup_tag,
    output logic                            o_lsu_busy
`ifdef ISSUE_UNIT_PERF_EN
    ,
    output logic [NUM_LANES-1:0][31:0]      o_perf_issue_cnt,
    output logic [31:0]                     o_perf_flush_cnt
`endif
);

    lsu_state_e                      r_lsu_state;
    lsu_state_e                      w_lsu_state_nxt;
    logic [TAG_W-1:0]                r_lsu_tag;
    logic [TAG_W-1:0]                w_lsu_tag_nxt;
    logic                            r_lsu_wake;
    logic [TAG_W-1:0]                r_lsu_wake_tag;
    logic                            w_lsu_complete;
    logic                            w_lsu_free;
    logic [NUM_LANES-1:0]            w_grant;
    logic [NUM_LANES-1:0][TAG_W-1:0] w_grant_tag;
    logic                            w_alu_valid;
    logic                            w_btu_valid;
    logic                            w_mult_valid;
    logic [TAG_W-1:0]                w_alu_tag;
    logic [TAG_W-1:0]                w_btu_tag;
    logic [TAG_W-1:0]                w_mult_tag;

    assign w_lsu_complete = (r_lsu_state == LSU_BUSY) && i_lsu_done;
    assign w_lsu_free     = (r_lsu_state == LSU_IDLE) || w_lsu_complete;

    // Grant arbitration; nothing issues during flush or while reset is held.
    always_comb begin
        w_grant     = 4'b0000;
        w_grant_tag = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            if (i_req_valid[j] && i_reset_n && !i_flush &&
                ((j != int'(LANE_LSU)) || w_lsu_free)) begin
                w_grant[j]     = 1'b1;
                w_grant_tag[j] = i_req_tag[j];
            end else begin
                w_grant[j]     = 1'b0;
                w_grant_tag[j] = {TAG_W{1'b0}};
            end
        end
    end

    assign o_issue_valid = w_grant;
    assign o_issue_tag   = w_grant_tag;
    assign o_clear       = w_grant;
    assign o_clear_tag   = w_grant_tag;
    assign o_lsu_busy    = !w_lsu_free;

    // LSU next-state: a completing op can hand the lane straight to a new grant.
    always_comb begin
        w_lsu_state_nxt = r_lsu_state;
        w_lsu_tag_nxt   = r_lsu_tag;
        case (r_lsu_state)
            LSU_IDLE: begin
                if (w_grant[LANE_LSU]) begin
                    w_lsu_state_nxt = LSU_BUSY;
                    w_lsu_tag_nxt   = i_req_tag[LANE_LSU];
                end else begin
                    w_lsu_state_nxt = LSU_IDLE;
                end
            end
            LSU_BUSY: begin
                if (i_flush) begin
                    w_lsu_state_nxt = i_lsu_done ? LSU_IDLE : LSU_DRAIN;
                end else if (i_lsu_done) begin
                    if (w_grant[LANE_LSU]) begin
                        w_lsu_state_nxt = LSU_BUSY;
                        w_lsu_tag_nxt   = i_req_tag[LANE_LSU];
                    end else begin
                        w_lsu_state_nxt = LSU_IDLE;
                    end
                end else begin
                    w_lsu_state_nxt = LSU_BUSY;
                end
            end
            LSU_DRAIN: begin
                if (i_lsu_done) begin
                    w_lsu_state_nxt = LSU_IDLE;
                end else begin
                    w_lsu_state_nxt = LSU_DRAIN;
                end
            end
            default: begin
                w_lsu_state_nxt = LSU_IDLE;
            end
        endcase
    end

    // LSU state, held tag and registered completion wakeup.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lsu_state    <= LSU_IDLE;
            r_lsu_tag      <= {TAG_W{1'b0}};
            r_lsu_wake     <= 1'b0;
            r_lsu_wake_tag <= {TAG_W{1'b0}};
        end else begin
            r_lsu_state    <= w_lsu_state_nxt;
            r_lsu_tag      <= w_lsu_tag_nxt;
            r_lsu_wake     <= w_lsu_complete && !i_flush;
            r_lsu_wake_tag <= (w_lsu_complete && !i_flush) ? r_lsu_tag : {TAG_W{1'b0}};
        end
    end

    fu_latency_pipe #(.DEPTH(1)) u_alu_pipe (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_flush   (i_flush),
        .i_valid   (w_grant[LANE_ALU]),
        .i_tag     (w_grant_tag[LANE_ALU]),
        .o_valid   (w_alu_valid),
        .o_tag     (w_alu_tag)
    );

    fu_latency_pipe #(.DEPTH(1)) u_btu_pipe (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_flush   (i_flush),
        .i_valid   (w_grant[LANE_BTU]),
        .i_tag     (w_grant_tag[LANE_BTU]),
        .o_valid   (w_btu_valid),
        .o_tag     (w_btu_tag)
    );

    fu_latency_pipe #(.DEPTH(MULT_LAT)) u_mult_pipe (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_flush   (i_flush),
        .i_valid   (w_grant[LANE_MULT]),
        .i_tag     (w_grant_tag[LANE_MULT]),
        .o_valid   (w_mult_valid),
        .o_tag     (w_mult_tag)
    );

    assign o_wakeup     = {w_alu_valid, w_btu_valid, w_mult_valid, r_lsu_wake};
    assign o_wakeup_tag = {w_alu_tag, w_btu_tag, w_mult_tag, r_lsu_wake_tag};

`ifdef ISSUE_UNIT_PERF_EN
    logic [NUM_LANES-1:0][31:0] r_perf_issue_cnt;
    logic [31:0]                r_perf_flush_cnt;

    // Saturating grant and flush counters.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_perf_issue_cnt <= '0;
            r_perf_flush_cnt <= 32'd0;
        end else begin
            for (int j = 0; j < NUM_LANES; j++) begin
                if (w_grant[j] && (r_perf_issue_cnt[j] != 32'hFFFF_FFFF)) begin
                    r_perf_issue_cnt[j] <= r_perf_issue_cnt[j] + 32'd1;
                end
            end
            if (i_flush && (r_perf_flush_cnt != 32'hFFFF_FFFF)) begin
                r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
            end
        end
    end

    assign o_perf_issue_cnt = r_perf_issue_cnt;
    assign o_perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_issue_unit.sv
// Self-checking bench for issue_unit against an event-list reference model.
module tb_issue_unit;

    localparam int TW       = issue_unit_pkg::TAG_W;
    localparam int MULT_LAT = 4;

    logic                 clk;
    logic                 rst_n;
    logic [3:0]           req_valid;
    logic [3:0][TW-1:0]   req_tag;
    logic                 flush;
    logic                 lsu_done;
    logic [3:0]           issue_valid;
    logic [3:0][TW-1:0]   issue_tag;
    logic [3:0]           clear;
    logic [3:0][TW-1:0]   clear_tag;
    logic [3:0]           wakeup;
    logic [3:0][TW-1:0]   wakeup_tag;
    logic                 lsu_busy;
`ifdef ISSUE_UNIT_PERF_EN
    logic [3:0][31:0]     perf_issue_cnt;
    logic [31:0]          perf_flush_cnt;
`endif

    issue_unit #(.MULT_LAT(MULT_LAT)) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_req_valid   (req_valid),
        .i_req_tag     (req_tag),
        .i_flush       (flush),
        .i_lsu_done    (lsu_done),
        .o_issue_valid (issue_valid),
        .o_issue_tag   (issue_tag),
        .o_clear       (clear),
        .o_clear_tag   (clear_tag),
        .o_wakeup      (wakeup),
        .o_wakeup_tag  (wakeup_tag),
        .o_lsu_busy    (lsu_busy)
`ifdef ISSUE_UNIT_PERF_EN
        ,
        .o_perf_issue_cnt (perf_issue_cnt),
        .o_perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: scheduled completions are a list of (lane, cycle, tag) events.
    typedef struct {
        int          lane;
        int          at;
        logic [TW-1:0] tag;
    } ev_t;

    ev_t              evq[$];
    int               cyc;
    int               lsu_mode;   // 0 free, 1 holding lsu_tag, 2 squashed op outstanding
    logic [TW-1:0]    lsu_tag;
    int               lat [4];
    logic [31:0]      m_issue_cnt [4];
    logic [31:0]      m_flush_cnt;
    logic [3:0]       e_issue;
    logic [3:0]       e_wake;
    logic [3:0][TW-1:0] e_itag;
    logic [3:0][TW-1:0] e_wtag;
    logic             e_busy;
    int               total;
    int               bad;

    task automatic drive(input logic [3:0] rv, input int t3, input int t2,
                         input int t1, input int t0, input logic fl, input logic dn);
        req_valid  = rv;
        req_tag[3] = TW'(t3);
        req_tag[2] = TW'(t2);
        req_tag[1] = TW'(t1);
        req_tag[0] = TW'(t0);
        flush      = fl;
        lsu_done   = dn;
    endtask

    // Settle the inputs, then compute what the DUT should present this cycle.
    task automatic settle_and_predict();
        logic lsu_ok;
        #1;
        e_issue = 4'b0; e_itag = '0; e_wake = 4'b0; e_wtag = '0; e_busy = 1'b0;
        if (rst_n) begin
            lsu_ok = (lsu_mode == 0) || (lsu_mode == 1 && lsu_done);
            e_busy = !lsu_ok;
            for (int j = 0; j < 4; j++) begin
                if (req_valid[j] && !flush && (j != 0 || lsu_ok)) begin
                    e_issue[j] = 1'b1;
                    e_itag[j]  = req_tag[j];
                end
            end
            foreach (evq[k]) begin
                if (evq[k].at == cyc) begin
                    e_wake[evq[k].lane] = 1'b1;
                    e_wtag[evq[k].lane] = evq[k].tag;
                end
            end
        end
    endtask

    // Apply this cycle's effects to the model and move to the next cycle.
    task automatic advance();
        ev_t keep[$];
        ev_t ev;
        if (!rst_n) begin
            evq.delete();
            lsu_mode = 0;
            lsu_tag  = '0;
            for (int j = 0; j < 4; j++) m_issue_cnt[j] = 32'd0;
            m_flush_cnt = 32'd0;
        end else begin
            foreach (evq[k]) if (!flush && evq[k].at > cyc) keep.push_back(evq[k]);
            evq = keep;
            for (int j = 1; j < 4; j++) begin
                if (e_issue[j]) begin
                    ev.lane = j; ev.at = cyc + lat[j]; ev.tag = e_itag[j];
                    evq.push_back(ev);
                end
            end
            case (lsu_mode)
                0: if (e_issue[0]) begin lsu_mode = 1; lsu_tag = e_itag[0]; end
                1: begin
                    if (flush) lsu_mode = lsu_done ? 0 : 2;
                    else if (lsu_done) begin
                        ev.lane = 0; ev.at = cyc + 1; ev.tag = lsu_tag;
                        evq.push_back(ev);
                        if (e_issue[0]) lsu_tag = e_itag[0];
                        else lsu_mode = 0;
                    end
                end
                default: if (lsu_done) lsu_mode = 0;
            endcase
            for (int j = 0; j < 4; j++)
                if (e_issue[j] && m_issue_cnt[j] != 32'hFFFF_FFFF) m_issue_cnt[j]++;
            if (flush && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(4'b1111, 1, 2, 3, 4, 1'b0, 1'b1);
            settle_and_predict();
            total++;
            if ({issue_valid, clear, issue_tag, clear_tag, lsu_busy, wakeup, wakeup_tag} !== '0) begin
                bad++;
                $display("FAIL reset cyc=%0d got iv=%b cl=%b busy=%b wk=%b wt=%h want all zero",
                         cyc, issue_valid, clear, lsu_busy, wakeup, wakeup_tag);
            end
            advance();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu_issue();
        int vec [3] = '{8, 0, 0};
        for (int i = 0; i < 3; i++) begin
            drive(4'(vec[i]), 5, 0, 0, 0, 1'b0, 1'b0);
            settle_and_predict();
            total++;
            if (i == 0 && (issue_valid[3] !== 1'b1 || clear[3] !== 1'b1 || clear_tag[3] !== TW'(5))) begin
                bad++;
                $display("FAIL alu_grant got iv=%b cl=%b ctag=%0d want 1 1 5", issue_valid[3], clear[3], clear_tag[3]);
            end
            total++;
            if ({wakeup, wakeup_tag} !== {e_wake, e_wtag}) begin
                bad++;
                $display("FAIL alu_wake cyc=%0d got wk=%b wt=%h want wk=%b wt=%h", cyc, wakeup, wakeup_tag, e_wake, e_wtag);
            end
            advance();
        end
    endtask

    task automatic test_mult_back_to_back();
        int seen;
        seen = 0;
        for (int i = 0; i < 9; i++) begin
            drive((i < 3) ? 4'b0010 : 4'b0000, 0, 0, i + 1, 0, 1'b0, 1'b0);
            settle_and_predict();
            total++;
            if ({issue_valid, issue_tag, wakeup, wakeup_tag} !== {e_issue, e_itag, e_wake, e_wtag}) begin
                bad++;
                $display("FAIL mult_b2b cyc=%0d got iv=%b wk=%b wt=%h want iv=%b wk=%b wt=%h",
                         cyc, issue_valid, wakeup, wakeup_tag, e_issue, e_wake, e_wtag);
            end
            if (i >= MULT_LAT && i < MULT_LAT + 3 && wakeup[1] === 1'b1 && wakeup_tag[1] === TW'(i - MULT_LAT + 1))
                seen++;
            advance();
        end
        total++;
        if (seen !== 3) begin
            bad++;
            $display("FAIL mult_b2b_count got %0d want 3", seen);
        end
    endtask

    task automatic test_lsu_handoff();
        // rv, lsu tag, done
        int rv [6] = '{1, 1, 1, 0, 0, 0};
        int tg [6] = '{7, 10, 8, 0, 0, 0};
        int dn [6] = '{0, 0, 1, 1, 0, 0};
        for (int i = 0; i < 6; i++) begin
            drive(4'(rv[i]), 0, 0, 0, tg[i], 1'b0, 1'(dn[i]));
            settle_and_predict();
            total++;
            if ({issue_valid, clear, issue_tag, lsu_busy} !== {e_issue, e_issue, e_itag, e_busy}) begin
                bad++;
                $display("FAIL lsu_issue cyc=%0d got iv=%b cl=%b tag=%h busy=%b want iv=%b tag=%h busy=%b",
                         cyc, issue_valid, clear, issue_tag, lsu_busy, e_issue, e_itag, e_busy);
            end
            total++;
            if ({wakeup, wakeup_tag} !== {e_wake, e_wtag}) begin
                bad++;
                $display("FAIL lsu_wake cyc=%0d got wk=%b wt=%h want wk=%b wt=%h", cyc, wakeup, wakeup_tag, e_wake, e_wtag);
            end
            advance();
        end
    endtask

    task automatic test_flush_mult();
        int tags_seen9;
        tags_seen9 = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) drive(4'b0010, 0, 0, 9, 0, 1'b0, 1'b0);
            else if (i == 2) drive(4'b1111, 11, 12, 13, 14, 1'b1, 1'b0);
            else drive(4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);
            settle_and_predict();
            total++;
            if ({issue_valid, clear, issue_tag, wakeup, wakeup_tag} !== {e_issue, e_issue, e_itag, e_wake, e_wtag}) begin
                bad++;
                $display("FAIL flush_mult cyc=%0d got iv=%b wk=%b wt=%h want iv=%b wk=%b wt=%h",
                         cyc, issue_valid, wakeup, wakeup_tag, e_issue, e_wake, e_wtag);
            end
            if (wakeup[1] === 1'b1 && wakeup_tag[1] === TW'(9)) tags_seen9++;
            advance();
        end
        total++;
        if (tags_seen9 !== 0) begin
            bad++;
            $display("FAIL flush_mult_stale got %0d wakeups for tag 9 want 0", tags_seen9);
        end
    endtask

    task automatic test_lsu_drain();
        int rv [9] = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
        int fl [9] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
        int dn [9] = '{0, 0, 0, 0, 1, 0, 1, 0, 0};
        int tg [9] = '{3, 0, 0, 0, 0, 4, 0, 0, 0};
        for (int i = 0; i < 9; i++) begin
            drive(4'(rv[i]), 0, 0, 0, tg[i], 1'(fl[i]), 1'(dn[i]));
            settle_and_predict();
            total++;
            if ({issue_valid, issue_tag, lsu_busy, wakeup, wakeup_tag} !== {e_issue, e_itag, e_busy, e_wake, e_wtag}) begin
                bad++;
                $display("FAIL lsu_drain cyc=%0d got iv=%b busy=%b wk=%b wt=%h want iv=%b busy=%b wk=%b wt=%h",
                         cyc, issue_valid, lsu_busy, wakeup, wakeup_tag, e_issue, e_busy, e_wake, e_wtag);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom_range(0, 15)), $urandom_range(0, 63), $urandom_range(0, 63),
                  $urandom_range(0, 63), $urandom_range(0, 63),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) == 0));
            settle_and_predict();
            total++;
            if ({issue_valid, clear, issue_tag, clear_tag, lsu_busy} !== {e_issue, e_issue, e_itag, e_itag, e_busy}) begin
                bad++;
                $display("FAIL rand_issue cyc=%0d got iv=%b cl=%b tag=%h busy=%b want iv=%b tag=%h busy=%b",
                         cyc, issue_valid, clear, issue_tag, lsu_busy, e_issue, e_itag, e_busy);
            end
            total++;
            if ({wakeup, wakeup_tag} !== {e_wake, e_wtag}) begin
                bad++;
                $display("FAIL rand_wake cyc=%0d got wk=%b wt=%h want wk=%b wt=%h", cyc, wakeup, wakeup_tag, e_wake, e_wtag);
            end
`ifdef ISSUE_UNIT_PERF_EN
            total++;
            if ({perf_issue_cnt[3], perf_issue_cnt[2], perf_issue_cnt[1], perf_issue_cnt[0], perf_flush_cnt} !==
                {m_issue_cnt[3], m_issue_cnt[2], m_issue_cnt[1], m_issue_cnt[0], m_flush_cnt}) begin
                bad++;
                $display("FAIL rand_perf cyc=%0d got %h/%0d want %0d %0d %0d %0d/%0d", cyc, perf_issue_cnt, perf_flush_cnt,
                         m_issue_cnt[3], m_issue_cnt[2], m_issue_cnt[1], m_issue_cnt[0], m_flush_cnt);
            end
`endif
            advance();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            if (i < 2) drive(4'b1111, 20 + i, 30 + i, 40 + i, 50 + i, 1'b0, 1'b0);
            else if (i == 3) drive(4'b1111, 1, 2, 3, 4, 1'b0, 1'b1);
            else drive(4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);
            if (i == 3) rst_n = 1'b0;
            if (i == 4) rst_n = 1'b1;
            settle_and_predict();
            total++;
            if ({issue_valid, issue_tag, lsu_busy, wakeup, wakeup_tag} !== {e_issue, e_itag, e_busy, e_wake, e_wtag}) begin
                bad++;
                $display("FAIL reset_mid cyc=%0d got iv=%b busy=%b wk=%b wt=%h want iv=%b busy=%b wk=%b wt=%h",
                         cyc, issue_valid, lsu_busy, wakeup, wakeup_tag, e_issue, e_busy, e_wake, e_wtag);
            end
`ifdef ISSUE_UNIT_PERF_EN
            total++;
            if (perf_issue_cnt[1] !== m_issue_cnt[1] || perf_flush_cnt !== m_flush_cnt) begin
                bad++;
                $display("FAIL reset_mid_perf cyc=%0d got %0d/%0d want %0d/%0d", cyc,
                         perf_issue_cnt[1], perf_flush_cnt, m_issue_cnt[1], m_flush_cnt);
            end
`endif
            advance();
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        lsu_mode = 0;
        lsu_tag  = '0;
        lat[0] = 1; lat[1] = MULT_LAT; lat[2] = 1; lat[3] = 1;
        for (int j = 0; j < 4; j++) m_issue_cnt[j] = 32'd0;
        m_flush_cnt = 32'd0;
        rst_n = 1'b0;
        drive(4'b0000, 0, 0, 0, 0, 1'b0, 1'b0);
        test_reset();
        test_alu_issue();
        test_mult_back_to_back();
        test_lsu_handoff();
        test_flush_mult();
        test_lsu_drain();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_unit.md
# issue_unit

Issue controller for the four functional-unit lanes fed by the per-lane reservation stations. Each cycle it grants issue to ready instructions, pulses `clear`/`clear_tag` back to the owning reservation station, and tracks in-flight destination tags through each lane's latency. It then drives the 4-wide `wakeup`/`wakeup_tag` broadcast consumed by all reservation stations. It also owns the squash path for in-flight operations on a pipeline flush.

## Interface
- MULT_LAT, 4: multiplier pipeline depth in cycles (≥1); fully pipelined.
- Lane index order everywhere: 0 = LSU, 1 = MULT, 2 = BTU, 3 = ALU.
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous, active-low; all state and registered outputs cleared while low.
- req_valid  in  [3:0]  per lane: reservation station presents a ready instruction.
- req_tag  in  [3:0][`ROB_TAG_LEN-1:0]  ROB tag of the presented instruction.
- flush  in  1  squash all in-flight and presented work this cycle.
- lsu_done  in  1  LSU completed its outstanding operation (single-cycle pulse).
- issue_valid  out  [3:0]  FU lane latches the instruction at the next edge.
- issue_tag  out  [3:0][`ROB_TAG_LEN-1:0]  tag issued to the lane.
- clear  out  [3:0]  per reservation station: remove entry `clear_tag`.
- clear_tag  out  [3:0][`ROB_TAG_LEN-1:0]  equals issue_tag.
- wakeup  out  [3:0]  registered completion broadcast.
- wakeup_tag  out  [3:0][`ROB_TAG_LEN-1:0]  completed tag per lane.
- lsu_busy  out  1  LSU lane cannot accept (state ≠ IDLE and not completing).

## Operation
- Lane available:
  - ALU, BTU, MULT: always, except during flush.
  - LSU: state IDLE, or state BUSY with lsu_done high, and no flush.
- Grant: issue_valid[j] = clear[j] = req_valid[j] & available[j] & !flush. This is combinational in the same cycle. issue_tag and clear_tag pass req_tag through; they are 0 when not granted.
- ALU/BTU: a grant in cycle t enters a depth-1 tag pipe; wakeup[j] is high in cycle t+1 with that tag.
- MULT: a grant in cycle t enters a depth-MULT_LAT tag pipe; wakeup[1] is high in cycle t+MULT_LAT. Back-to-back grants produce back-to-back wakeups.
- LSU FSM:
  - IDLE: grant → BUSY, tag stored.
  - BUSY: lsu_done → registered wakeup[0] next cycle with the stored tag. Go to IDLE, or stay BUSY with the new tag if a new grant happens the same cycle. flush without lsu_done → DRAIN.
  - DRAIN: waits for lsu_done, produces no wakeup, then → IDLE.
  - BUSY with flush and lsu_done in the same cycle → IDLE, no wakeup.
- Flush in cycle t:
  - Grants are suppressed in t.
  - All tag-pipe valid bits clear at the t→t+1 edge, so no wakeup from pre-flush issue appears in t+1 or later.
  - A wakeup already visible in cycle t is not retracted.
- wakeup_tag[j] is 0 whenever wakeup[j] is 0.

## Timing
- Reset values: every output is 0; LSU state is IDLE; all pipe valids are 0.
- Issue latency: 0 cycles from req_valid (combinational). Reservation station entries clear at the following edge.
- Completion latency (issue → wakeup): ALU/BTU 1 cycle, MULT MULT_LAT cycles, LSU 1 cycle after lsu_done.
- Reset asserted mid-operation discards all in-flight tags. There is no wakeup after reset release until new grants complete.
- lsu_done in IDLE is ignored.

## Configuration
- ISSUE_UNIT_PERF_EN defined:
  - Adds `perf_issue_cnt` out [3:0][31:0]: per-lane count of issue_valid cycles.
  - Adds `perf_flush_cnt` out [31:0]: count of cycles with flush high.
  - Counters saturate at all-ones and reset to 0.
- ISSUE_UNIT_PERF_EN undefined: these ports and counters are absent. Function is otherwise identical.

## Structure
- `issue_unit.svh` holds:
  - FU_LANE enum (LANE_LSU = 0, LANE_MULT = 1, LANE_BTU = 2, LANE_ALU = 3) and NUM_LANES = 4.
  - LSU_STATE enum (LSU_IDLE, LSU_BUSY, LSU_DRAIN).
- `ROB_TAG_LEN comes from sys_defs.svh.
- One sub-module, `fu_latency_pipe`:
  - Parameter DEPTH.
  - Ports: in valid/tag, flush; out valid/tag.
  - It is a valid+tag shift register whose flush clears all valid bits.
  - Instantiated for ALU and BTU (DEPTH = 1) and MULT (DEPTH = MULT_LAT).

## Test plan
- Reset released, req_valid = 4'b1000 with tag 5 in cycle 0 → issue_valid[3] = clear[3] = 1, clear_tag[3] = 5 in cycle 0; wakeup[3] = 1 with tag 5 in cycle 1, 0 in cycle 2.
- MULT grants of tags 1, 2, 3 in consecutive cycles 0–2 with MULT_LAT = 4 → wakeup[1] in cycles 4, 5, 6 with tags 1, 2, 3.
- LSU tag 7 granted; second LSU request while BUSY → no grant and lsu_busy = 1. lsu_done plus new request tag 8 in the same cycle → tag 8 granted and wakeup[0] tag 7 next cycle.
- MULT tag 9 issued, flush 2 cycles later → no wakeup[1] ever for tag 9; requests in the flush cycle are not granted.
- LSU BUSY, flush → DRAIN; lsu_done 3 cycles later → no wakeup[0], state IDLE, next LSU request granted.
- reset pulled low mid-MULT pipe → all outputs 0 immediately; no stale wakeup after release. With ISSUE_UNIT_PERF_EN, counters read 0 after reset and increment once per grant.
